// File: rtl/bram_rd_arbiter.sv
`timescale 1ns/1ps
// Round-robin arbiter sharing one BRAM read port among NUM_REQ requesters; write port passes through.
// Optional macro BRAM_ARB_WR_BYPASS_EN: forward same-cycle write data to a colliding read instead of stalling it.
module bram_rd_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 2
) (
  input  logic                          CLK,
  input  logic                          rst_b,
  input  logic [NUM_REQ-1:0]            rd_req,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] rd_addr_in,
  output logic [NUM_REQ-1:0]            rd_gnt,
  input  logic                          wr_valid,
  input  logic [ADDR_WIDTH-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0]         wr_data,
  output logic                          rsp_valid,
  output logic [ID_WIDTH-1:0]           rsp_id,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  input  logic                          rsp_ready,
  output logic                          bram_rd_en,
  output logic [ADDR_WIDTH-1:0]         bram_rd_addr,
  output logic                          bram_wr_en,
  output logic [ADDR_WIDTH-1:0]         bram_wr_addr,
  output logic [DATA_WIDTH-1:0]         bram_wbl,
  input  logic [DATA_WIDTH-1:0]         bram_arbl
);

  logic [ID_WIDTH-1:0]   rr_ptr;
  logic [ID_WIDTH-1:0]   win_idx;
  logic                  found;
  logic                  can_issue;
  logic                  collision;
  logic                  grant;
  logic [ADDR_WIDTH-1:0] win_addr;

  // Cyclic scan starting at rr_ptr; the first requester found wins.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && rd_req[(int'(rr_ptr) + k) % NUM_REQ]) begin
        found   = 1'b1;
        win_idx = ID_WIDTH'((int'(rr_ptr) + k) % NUM_REQ);
      end
    end
  end

  assign win_addr  = rd_addr_in[int'(win_idx)*ADDR_WIDTH +: ADDR_WIDTH];
  assign can_issue = !rsp_valid || rsp_ready;
  assign collision = wr_valid && (wr_addr == win_addr);

`ifdef BRAM_ARB_WR_BYPASS_EN
  assign grant = rst_b && found && can_issue;
`else
  assign grant = rst_b && found && can_issue && !collision;
`endif

  assign rd_gnt       = grant ? (NUM_REQ'(1) << win_idx) : '0;
  assign bram_rd_en   = grant;
  assign bram_rd_addr = win_addr;
  assign bram_wr_en   = wr_valid & rst_b;
  assign bram_wr_addr = wr_addr;
  assign bram_wbl     = wr_data;

  // Handshake: a response is transferred on any edge where rsp_valid && rsp_ready.
  always_ff @(posedge CLK) begin
    if (!rst_b) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rr_ptr    <= '0;
    end else if (grant) begin
      rsp_valid <= 1'b1;
      rsp_id    <= win_idx;
      rr_ptr    <= (win_idx == ID_WIDTH'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
    end else if (rsp_valid && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

`ifdef BRAM_ARB_WR_BYPASS_EN
  logic                  byp_flag;
  logic [DATA_WIDTH-1:0] byp_data;

  // The BRAM returns old data on a read-during-write, so the written word is held here instead.
  always_ff @(posedge CLK) begin
    if (!rst_b) begin
      byp_flag <= 1'b0;
    end else if (grant) begin
      byp_flag <= collision;
      byp_data <= wr_data;
    end else if (rsp_valid && rsp_ready) begin
      byp_flag <= 1'b0;
    end
  end

  assign rsp_data = byp_flag ? byp_data : bram_arbl;
`else
  assign rsp_data = bram_arbl;
`endif

endmodule

// File: tb/tb_bram_rd_arbiter.sv
`timescale 1ns/1ps
// Directed bench for bram_rd_arbiter with a behavioural registered-read BRAM model.
module tb_bram_rd_arbiter;
  localparam int NR = 4;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int IW = 2;

  logic            CLK = 1'b0;
  logic            rst_b;
  logic [NR-1:0]   rd_req;
  logic [NR*AW-1:0] rd_addr_in;
  logic [NR-1:0]   rd_gnt;
  logic            wr_valid;
  logic [AW-1:0]   wr_addr;
  logic [DW-1:0]   wr_data;
  logic            rsp_valid;
  logic [IW-1:0]   rsp_id;
  logic [DW-1:0]   rsp_data;
  logic            rsp_ready;
  logic            bram_rd_en;
  logic [AW-1:0]   bram_rd_addr;
  logic            bram_wr_en;
  logic [AW-1:0]   bram_wr_addr;
  logic [DW-1:0]   bram_wbl;
  logic [DW-1:0]   bram_arbl = '0;
  logic [DW-1:0]   mem [0:1023];

  int n_checks = 0;
  int n_fail   = 0;
  logic [IW+DW-1:0] exp_q[$];

  bram_rd_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
    .CLK(CLK), .rst_b(rst_b), .rd_req(rd_req), .rd_addr_in(rd_addr_in), .rd_gnt(rd_gnt),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
    .bram_rd_en(bram_rd_en), .bram_rd_addr(bram_rd_addr), .bram_wr_en(bram_wr_en),
    .bram_wr_addr(bram_wr_addr), .bram_wbl(bram_wbl), .bram_arbl(bram_arbl)
  );

  // Clock and BRAM model: registered read, ARBL held when rd_en is low, old data on read-during-write.
  always #5 CLK = ~CLK;
  always @(posedge CLK) begin
    if (bram_wr_en) mem[bram_wr_addr] <= bram_wbl;
    if (bram_rd_en) bram_arbl <= mem[bram_rd_addr];
  end

  typedef struct {
    logic [NR-1:0]    req;
    logic [NR*AW-1:0] addrs;
    logic             wv;
    logic [AW-1:0]    wa;
    logic [DW-1:0]    wd;
    logic             rdy;
    logic [NR-1:0]    gnt;
    logic             rv;
    logic [IW-1:0]    rid;
    logic [DW-1:0]    rdata;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs [NV];

  function automatic vec_t mk(logic [NR-1:0] req, logic [NR*AW-1:0] addrs, logic wv, logic [AW-1:0] wa,
                              logic [DW-1:0] wd, logic rdy, logic [NR-1:0] gnt, logic rv,
                              logic [IW-1:0] rid, logic [DW-1:0] rdata);
    vec_t v;
    v.req = req; v.addrs = addrs; v.wv = wv; v.wa = wa; v.wd = wd; v.rdy = rdy;
    v.gnt = gnt; v.rv = rv; v.rid = rid; v.rdata = rdata;
    return v;
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [NR-1:0] req, input logic [NR*AW-1:0] addrs, input logic wv,
                       input logic [AW-1:0] wa, input logic [DW-1:0] wd, input logic rdy);
    @(negedge CLK);
    rd_req = req; rd_addr_in = addrs; wr_valid = wv; wr_addr = wa; wr_data = wd; rsp_ready = rdy;
    #1;
  endtask

  function automatic logic [DW-1:0] dat(input int i);
    return 32'h1000_000A + DW'(i);
  endfunction

  logic [NR*AW-1:0] addr_a;
  logic [NR*AW-1:0] addr_s;
  logic [NR*AW-1:0] addr_c;
  logic [11:0]      rdy_pat;
  logic [IW+DW-1:0] exp_e;
  int               pops;

  initial begin
    rst_b = 1'b0; rd_req = '0; rd_addr_in = '0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0; rsp_ready = 1'b1;
    addr_a = {10'd13, 10'd12, 10'd11, 10'd10};
    addr_s = {10'd13, 10'd5,  10'd11, 10'd10};
    addr_c = {10'd13, 10'd12, 10'd11, 10'd7};

    // Round robin from reset pointer 0, then backpressure, then single read of a fresh write.
    vecs[0]  = mk(4'hF, addr_a, 0, 0, 0, 1, 4'b0001, 0, 0, 0);
    vecs[1]  = mk(4'hF, addr_a, 0, 0, 0, 1, 4'b0010, 1, 0, dat(0));
    vecs[2]  = mk(4'hF, addr_a, 0, 0, 0, 1, 4'b0100, 1, 1, dat(1));
    vecs[3]  = mk(4'hF, addr_a, 0, 0, 0, 1, 4'b1000, 1, 2, dat(2));
    vecs[4]  = mk(4'hF, addr_a, 0, 0, 0, 1, 4'b0001, 1, 3, dat(3));
    vecs[5]  = mk(4'hF, addr_a, 0, 0, 0, 1, 4'b0010, 1, 0, dat(0));
    vecs[6]  = mk(4'hF, addr_a, 0, 0, 0, 0, 4'b0000, 1, 1, dat(1));
    vecs[7]  = mk(4'hF, addr_a, 0, 0, 0, 0, 4'b0000, 1, 1, dat(1));
    vecs[8]  = mk(4'hF, addr_a, 0, 0, 0, 0, 4'b0000, 1, 1, dat(1));
    vecs[9]  = mk(4'hF, addr_a, 0, 0, 0, 1, 4'b0100, 1, 1, dat(1));
    vecs[10] = mk(4'h0, addr_a, 0, 0, 0, 1, 4'b0000, 1, 2, dat(2));
    vecs[11] = mk(4'h0, addr_s, 1, 5, 32'hDEAD_BEEF, 1, 4'b0000, 0, 0, 0);
    vecs[12] = mk(4'h0, addr_s, 0, 0, 0, 1, 4'b0000, 0, 0, 0);
    vecs[13] = mk(4'b0100, addr_s, 0, 0, 0, 1, 4'b0100, 0, 0, 0);
    vecs[14] = mk(4'h0, addr_s, 0, 0, 0, 1, 4'b0000, 1, 2, 32'hDEAD_BEEF);
    vecs[15] = mk(4'h0, addr_s, 0, 0, 0, 1, 4'b0000, 0, 0, 0);

    // Reset state with requests and a write presented.
    repeat (2) @(posedge CLK);
    drive(4'hF, addr_a, 1, 10'd3, 32'h55, 1);
    check("rst rd_gnt", DW'(rd_gnt), 0);
    check("rst bram_rd_en", DW'(bram_rd_en), 0);
    check("rst bram_wr_en", DW'(bram_wr_en), 0);
    check("rst rsp_valid", DW'(rsp_valid), 0);
    check("rst rsp_id", DW'(rsp_id), 0);
    @(negedge CLK);
    rst_b = 1'b1; rd_req = '0; wr_valid = 1'b0;

    for (int a = 10; a < 14; a++) drive(4'h0, addr_a, 1, AW'(a), 32'h1000_0000 | DW'(a), 1);
    drive(4'h0, addr_a, 1, 10'd7, 32'h1, 1);

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].req, vecs[i].addrs, vecs[i].wv, vecs[i].wa, vecs[i].wd, vecs[i].rdy);
      check($sformatf("v%0d rd_gnt", i), DW'(rd_gnt), DW'(vecs[i].gnt));
      check($sformatf("v%0d bram_rd_en", i), DW'(bram_rd_en), DW'(vecs[i].gnt != 0));
      check($sformatf("v%0d rsp_valid", i), DW'(rsp_valid), DW'(vecs[i].rv));
      if (vecs[i].rv) begin
        check($sformatf("v%0d rsp_id", i), DW'(rsp_id), DW'(vecs[i].rid));
        check($sformatf("v%0d rsp_data", i), rsp_data, vecs[i].rdata);
      end
    end

    // Read-during-write collision on addr 7 (old value 0x1, new value 0x2); pointer is at 3 here.
    drive(4'b0001, addr_c, 1, 10'd7, 32'h2, 1);
    check("col wr_en", DW'(bram_wr_en), 1);
`ifdef BRAM_ARB_WR_BYPASS_EN
    check("col gnt", DW'(rd_gnt), 32'b0001);
    drive(4'b0000, addr_c, 0, 0, 0, 1);
    check("col rsp_valid", DW'(rsp_valid), 1);
    check("col rsp_id", DW'(rsp_id), 0);
    check("col rsp_data", rsp_data, 32'h2);
    drive(4'b0000, addr_c, 0, 0, 0, 1);
    check("col retire", DW'(rsp_valid), 0);
`else
    check("col gnt stall", DW'(rd_gnt), 0);
    drive(4'b0001, addr_c, 0, 0, 0, 1);
    check("col gnt late", DW'(rd_gnt), 32'b0001);
    check("col rsp_valid early", DW'(rsp_valid), 0);
    drive(4'b0000, addr_c, 0, 0, 0, 1);
    check("col rsp_valid", DW'(rsp_valid), 1);
    check("col rsp_id", DW'(rsp_id), 0);
    check("col rsp_data", rsp_data, 32'h2);
`endif

    // Continuous requests with an irregular ready pattern: responses must come back in cyclic order from 1.
    for (int k = 0; k < 14; k++) exp_q.push_back({IW'((1 + k) % NR), dat((1 + k) % NR)});
    rdy_pat = 12'b1101_1100_1101;
    pops = 0;
    for (int c = 0; c < 12; c++) begin
      drive(4'hF, addr_a, 0, 0, 0, rdy_pat[c]);
      if (rsp_valid && rsp_ready) begin
        exp_e = exp_q.pop_front();
        pops++;
        check($sformatf("q%0d rsp_id", c), DW'(rsp_id), DW'(exp_e[IW+DW-1:DW]));
        check($sformatf("q%0d rsp_data", c), rsp_data, exp_e[DW-1:0]);
      end
    end
    check("q accepted count", DW'(pops), 7);

    // Reset while a response is pending and the pointer sits at 1.
    drive(4'b0001, addr_a, 0, 0, 0, 1);
    check("pre-rst gnt", DW'(rd_gnt), 32'b0001);
    drive(4'hF, addr_a, 1, 10'd20, 32'h77, 0);
    check("pre-rst rsp_valid", DW'(rsp_valid), 1);
    check("pre-rst no gnt", DW'(rd_gnt), 0);
    @(negedge CLK);
    rst_b = 1'b0;
    #1;
    check("mid-rst rd_gnt", DW'(rd_gnt), 0);
    check("mid-rst bram_rd_en", DW'(bram_rd_en), 0);
    check("mid-rst bram_wr_en", DW'(bram_wr_en), 0);
    drive(4'hF, addr_a, 0, 0, 0, 0);
    rst_b = 1'b1;
    #1;
    check("post-rst rsp_valid", DW'(rsp_valid), 0);
    check("post-rst rsp_id", DW'(rsp_id), 0);
    check("post-rst first gnt", DW'(rd_gnt), 32'b0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/bram_rd_arbiter.md
# bram_rd_arbiter

Round-robin arbiter that shares the single read port of one `bram_m20k` instance among `NUM_REQ` read requesters. The single write port passes straight through. Each grant issues exactly one BRAM read. The registered read data is returned one cycle later as a tagged response with valid/ready backpressure. The block sits between the SpMV merge-stage readers and the on-chip brick memory; it is the only driver of the BRAM control pins.

## Interface

**Parameters**
- `NUM_REQ`, default 4: number of read requesters, 2..8.
- `ADDR_WIDTH`, default 10: BRAM address width.
- `DATA_WIDTH`, default 32: BRAM word width.
- `ID_WIDTH`, default 2: response tag width, equal to ceil(log2(`NUM_REQ`)).

**Ports** (name, direction, width, meaning)
- `CLK` — in — 1 — single clock, rising edge.
- `rst_b` — in — 1 — reset; synchronous, active-low.
- `rd_req` — in — NUM_REQ — per-requester read request; held until granted.
- `rd_addr_in` — in — NUM_REQ*ADDR_WIDTH — packed per-requester read address; slice i belongs to requester i.
- `rd_gnt` — out — NUM_REQ — one-hot grant, combinational; the read issues in this cycle.
- `wr_valid` — in — 1 — write request; always accepted.
- `wr_addr` — in — ADDR_WIDTH — write address.
- `wr_data` — in — DATA_WIDTH — write data.
- `rsp_valid` — out — 1 — response valid.
- `rsp_id` — out — ID_WIDTH — index of the requester the response belongs to.
- `rsp_data` — out — DATA_WIDTH — read data.
- `rsp_ready` — in — 1 — consumer accepts the response.
- `bram_rd_en` — out — 1 — drives BRAM `rd_en`.
- `bram_rd_addr` — out — ADDR_WIDTH — drives BRAM `rd_addr`.
- `bram_wr_en` — out — 1 — drives BRAM `wr_en`.
- `bram_wr_addr` — out — ADDR_WIDTH — drives BRAM `wr_addr`.
- `bram_wbl` — out — DATA_WIDTH — drives BRAM `WBL`.
- `bram_arbl` — in — DATA_WIDTH — from BRAM `ARBL`.

## Operation

**Issue slot**
- `can_issue = !rsp_valid || rsp_ready`.
- At most one read is issued per cycle.

**Arbitration**
- Round-robin pointer `rr_ptr` marks the highest-priority requester.
- The winner is the first i with `rd_req[i]` set, scanning cyclically from `rr_ptr`.
- Winner i is granted when `can_issue` holds and no collision stall applies (see Configuration).
- On a grant, `rr_ptr` becomes (i+1) mod NUM_REQ. Otherwise `rr_ptr` is unchanged.

**Read issue**
- In the grant cycle: `bram_rd_en=1`, `bram_rd_addr` = slice i of `rd_addr_in`.
- `rsp_id` is registered as i, and `rsp_valid` is set on the next edge.

**Response hold**
- While `rsp_valid && !rsp_ready`, no read issues.
- With `bram_rd_en=0`, the BRAM holds `ARBL`, so `rsp_data` stays stable.

**Response retire**
- `rsp_valid && rsp_ready` with no new grant clears `rsp_valid`.
- With a new grant in the same cycle, `rsp_valid` stays 1 and the response is replaced.

**Write path**
- `bram_wr_en = wr_valid & rst_b`; `bram_wr_addr = wr_addr`; `bram_wbl = wr_data`.
- The write port never stalls.

**Read-during-write collision**
- A collision is a read issued in the same cycle as a write with an equal address.
- Handling depends on the configuration macro.

**Reset**
- Reset is `rst_b` low at the clock edge.
- Register values after reset: `rsp_valid=0`, `rsp_id=0`, `rr_ptr=0`, bypass state cleared.
- While `rst_b=0`: `rd_gnt=0`, `bram_rd_en=0`, `bram_wr_en=0`.
- Any outstanding response is dropped.
- `rsp_data` is don't-care whenever `rsp_valid=0`.

## Timing
- Grant to response: grant in cycle N gives `rsp_valid=1` in cycle N+1 with the data.
- Throughput: one read per cycle when `rsp_ready` is held high.
- Backpressure: `rsp_ready=0` while `rsp_valid=1` stalls grants in the same cycle; there is no extra bubble when ready returns.
- Grants are combinational from `rd_req`, `rsp_valid`, `rsp_ready`, `wr_valid`, `wr_addr` and the address slices. Requesters must not make `rd_req` depend on `rd_gnt`.
- Write data becomes readable by reads issued in the cycle after the write. Same-cycle visibility follows Configuration.
- Reset mid-response: `rsp_valid` is low in the cycle after the reset edge, regardless of `rsp_ready`.

## Configuration
- Macro: `BRAM_ARB_WR_BYPASS_EN`.
- **Defined:**
  - A collision read still issues.
  - `wr_data` is captured into a bypass register with a bypass flag.
  - In the response cycle, `rsp_data` = bypass register, not `bram_arbl`.
  - The flag holds until the response retires or is replaced.
- **Undefined:**
  - A collision withholds the grant for that cycle; `rr_ptr` is unchanged.
  - The read issues in the next cycle and returns the new data from the BRAM.

## Test plan
- **Single read:** write addr 5 = 0xDEAD_BEEF. Two cycles later, requester 2 reads addr 5 → `rd_gnt=4'b0100`; next cycle `rsp_valid=1`, `rsp_id=2`, `rsp_data=0xDEAD_BEEF`.
- **Round-robin fairness:** all four requesters request continuously with `rsp_ready=1` → grant order 0,1,2,3,0,1 on consecutive cycles; `rsp_id` follows one cycle behind.
- **Backpressure:** `rsp_ready=0` for 3 cycles with a pending response and `rd_req=4'b1111` → no grants, `rsp_data` constant. Ready high → a grant issues in the same cycle.
- **Collision, bypass defined:**
  - Setup: addr 7 holds 0x1; write 0x2 to addr 7 in the same cycle requester 0 reads addr 7.
  - With `BRAM_ARB_WR_BYPASS_EN` → response `rsp_data=0x2` the next cycle.
- **Collision, bypass undefined:** same stimulus → grant delayed one cycle; `rsp_data=0x2` two cycles after the request.
- **Reset mid-operation:**
  - Stimulus: `rst_b` low for one edge while `rsp_valid=1` and requests are pending.
  - Response: next cycle `rsp_valid=0`, `rd_gnt=0`, `bram_wr_en=0`; after reset, the first grant goes to requester 0.
